// File: rtl/sha1_padder_if.sv
// Byte-stream input and padded-block output bundle for the SHA-1 padder.
// The slave modport is the padder itself; master is the surrounding logic
// that feeds bytes and pulls finished blocks.
interface sha1_padder_if;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_keep;
    logic         in_last;
    logic [511:0] block_out;
    logic         block_valid;
    logic         block_last;
    logic         block_ready;

    modport slave (
        input  in_valid, in_data, in_keep, in_last, block_ready,
        output in_ready, block_out, block_valid, block_last
    );

    modport master (
        output in_valid, in_data, in_keep, in_last, block_ready,
        input  in_ready, block_out, block_valid, block_last
    );
endinterface

// File: rtl/sha1_padder.sv
// SHA-1 message padder: collects bytes into 512-bit blocks, appends the
// 0x80 marker, zero fill and the 64-bit big-endian bit length, and hands
// each finished block out through a valid/ready handshake. Byte k of a
// block lands in word k/4, with the first byte of a word in its top bits.
module sha1_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    sha1_padder_if.slave bus
);

    typedef enum logic [2:0] {
        S_FILL = 3'd0,
        S_PAD  = 3'd1,
        S_ZERO = 3'd2,
        S_LEN  = 3'd3,
        S_EMIT = 3'd4
    } state_t;

    state_t             r_state;
    state_t             r_ret;
    logic [5:0]         r_pos;
    logic [LEN_W-1:0]   r_bitlen;
    logic [511:0]       r_buf;
    logic               r_last;
    logic               r_in_ready;
    logic               r_block_valid;

    state_t             w_state;
    state_t             w_ret;
    logic [5:0]         w_pos;
    logic [LEN_W-1:0]   w_bitlen;
    logic [511:0]       w_buf;
    logic               w_last;
    logic [63:0]        w_len64;
    logic               w_beat;

    // Place one byte at block position pos (first byte of a word in its MSBs).
    function automatic logic [511:0] put_byte(input logic [511:0] blk,
                                              input logic [5:0]   pos,
                                              input logic [7:0]   val);
        logic [511:0] res;
        logic [8:0]   lsb;
        res = blk;
        lsb = {pos[5:2], 5'b00000} + 9'd24 - {4'b0000, pos[1:0], 3'b000};
        res[lsb +: 8] = val;
        return res;
    endfunction

    assign w_len64 = 64'(r_bitlen);
    assign w_beat  = bus.in_valid & r_in_ready;

    // Next-state and datapath update for the padding sequence.
    always_comb begin
        w_state  = r_state;
        w_ret    = r_ret;
        w_pos    = r_pos;
        w_bitlen = r_bitlen;
        w_buf    = r_buf;
        w_last   = r_last;
        case (r_state)
            S_FILL: begin
                if (w_beat) begin
                    if (bus.in_keep) begin
                        w_buf    = put_byte(r_buf, r_pos, bus.in_data);
                        w_pos    = r_pos + 6'd1;
                        w_bitlen = r_bitlen + LEN_W'(4'd8);
                        if (bus.in_last && (r_pos == 6'd63)) begin
                            // Final byte filled the block: ship it, pad into a fresh one.
                            w_state = S_EMIT;
                            w_ret   = S_PAD;
                            w_last  = 1'b0;
                        end else if (bus.in_last) begin
                            w_state = S_PAD;
                        end else if (r_pos == 6'd63) begin
                            w_state = S_EMIT;
                            w_ret   = S_FILL;
                            w_last  = 1'b0;
                        end else begin
                            w_state = S_FILL;
                        end
                    end else if (bus.in_last) begin
                        w_state = S_PAD;
                    end else begin
                        w_state = S_FILL;
                    end
                end else begin
                    w_state = S_FILL;
                end
            end
            S_PAD: begin
                w_buf = put_byte(r_buf, r_pos, 8'h80);
                w_pos = r_pos + 6'd1;
                if (r_pos == 6'd55) begin
                    w_state = S_LEN;
                end else if (r_pos == 6'd63) begin
                    w_state = S_EMIT;
                    w_ret   = S_ZERO;
                    w_last  = 1'b0;
                end else begin
                    w_state = S_ZERO;
                end
            end
            S_ZERO: begin
                w_buf = put_byte(r_buf, r_pos, 8'h00);
                w_pos = r_pos + 6'd1;
                if (r_pos == 6'd55) begin
                    w_state = S_LEN;
                end else if (r_pos == 6'd63) begin
                    w_state = S_EMIT;
                    w_ret   = S_ZERO;
                    w_last  = 1'b0;
                end else begin
                    w_state = S_ZERO;
                end
            end
            S_LEN: begin
                w_buf[479:448] = w_len64[63:32];
                w_buf[511:480] = w_len64[31:0];
                w_pos          = 6'd0;
                w_state        = S_EMIT;
                w_ret          = S_FILL;
                w_last         = 1'b1;
            end
            S_EMIT: begin
                if (bus.block_ready) begin
                    w_buf   = '0;
                    w_pos   = 6'd0;
                    w_state = r_ret;
                    w_last  = 1'b0;
                    if (r_last) begin
                        w_bitlen = '0;
                    end else begin
                        w_bitlen = r_bitlen;
                    end
                end else begin
                    w_state = S_EMIT;
                end
            end
            default: begin
                w_state  = S_FILL;
                w_ret    = S_FILL;
                w_pos    = 6'd0;
                w_bitlen = '0;
                w_buf    = '0;
                w_last   = 1'b0;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_FILL;
            r_ret         <= S_FILL;
            r_pos         <= 6'd0;
            r_bitlen      <= '0;
            r_buf         <= '0;
            r_last        <= 1'b0;
            r_in_ready    <= 1'b1;
            r_block_valid <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_ret         <= w_ret;
            r_pos         <= w_pos;
            r_bitlen      <= w_bitlen;
            r_buf         <= w_buf;
            r_last        <= w_last;
            r_in_ready    <= (w_state == S_FILL);
            r_block_valid <= (w_state == S_EMIT);
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.block_valid = r_block_valid;
    assign bus.block_last  = r_last;
    assign bus.block_out   = r_buf;

endmodule

// File: tb/tb_sha1_padder.sv
// Directed bench for sha1_padder. A message-level model pads each byte
// string (0x80, zeros to 56 mod 64, 64-bit big-endian bit length) and
// queues the expected blocks; a single compare process checks every block
// transfer against that queue, plus literal word checks on known messages.
module tb_sha1_padder;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [511:0] data;
        logic         last;
    } blk_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sha1_padder_if bus ();

    sha1_padder #(.LEN_W(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    blk_t         exp_q[$];
    logic [511:0] got_q[$];
    bit           hold        = 1'b0;
    logic [511:0] hold_d;
    logic         hold_l;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // Expected blocks for a complete message, from the padding rule itself.
    function automatic void model_push(input bq_t msg);
        bq_t         p;
        logic [63:0] len;
        int          nb;
        blk_t        e;
        p   = msg;
        len = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            for (int k = 0; k < 64; k++)
                e.data[(k/4)*32 + (3 - (k%4))*8 +: 8] = p[b*64 + k];
            e.last = (b == nb - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Compare process: every block transfer, plus hold-stability under backpressure.
    initial begin
        blk_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset_n !== 1'b1) begin
                hold = 1'b0;
            end else begin
                if (bus.block_valid === 1'b1) begin
                    check("in_ready_during_emit", {511'd0, bus.in_ready}, 512'd0);
                    if (hold) begin
                        check("hold_block_out", bus.block_out, hold_d);
                        check("hold_block_last", {511'd0, bus.block_last}, {511'd0, hold_l});
                    end
                end
                if (bus.block_valid === 1'b1 && bus.block_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_block");
                    end else begin
                        e = exp_q.pop_front();
                        check("block_out", bus.block_out, e.data);
                        check("block_last", {511'd0, bus.block_last}, {511'd0, e.last});
                    end
                    got_q.push_back(bus.block_out);
                end
                hold   = (bus.block_valid === 1'b1) && (bus.block_ready !== 1'b1);
                hold_d = bus.block_out;
                hold_l = bus.block_last;
            end
        end
    end

    // One input beat; called and returns at a falling edge.
    task automatic beat(input logic [7:0] d, input logic k, input logic l);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_keep  = k;
        bus.in_last  = l;
        while (bus.in_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_now("beat_timeout");
        @(negedge clk);
    endtask

    task automatic send(input bq_t msg, input bit do_last);
        if (do_last) model_push(msg);
        if (msg.size() == 0) begin
            beat(8'h00, 1'b0, do_last);
        end else begin
            for (int i = 0; i < msg.size(); i++)
                beat(msg[i], 1'b1, do_last && (i == msg.size() - 1));
        end
        bus.in_valid = 1'b0;
        bus.in_keep  = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    task automatic pin(input string name, input int idx, input int word, input logic [31:0] exp);
        logic [511:0] b;
        if (idx >= got_q.size()) begin
            fail_now({name, "_missing_block"});
        end else begin
            b = got_q[idx];
            check(name, {480'd0, b[word*32 +: 32]}, {480'd0, exp});
        end
    endtask

    task automatic pin_abc();
        pin("abc_w0", 0, 0, 32'h61626380);
        for (int w = 1; w < 15; w++) pin("abc_wmid", 0, w, 32'h00000000);
        pin("abc_w15", 0, 15, 32'h00000018);
    endtask

    initial begin
        bq_t m;
        int  t0;
        int  n;
        bus.in_valid    = 1'b0;
        bus.in_data     = 8'h00;
        bus.in_keep     = 1'b0;
        bus.in_last     = 1'b0;
        bus.block_ready = 1'b1;
        reset_n         = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {511'd0, bus.in_ready}, {511'd0, 1'b1});
        check("rst_block_valid", {511'd0, bus.block_valid}, 512'd0);
        check("rst_block_last", {511'd0, bus.block_last}, 512'd0);
        check("rst_block_out", bus.block_out, 512'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // "abc" with latency from last beat to block_valid.
        m = {8'h61, 8'h62, 8'h63};
        model_push(m);
        beat(8'h61, 1'b1, 1'b0);
        beat(8'h62, 1'b1, 1'b0);
        beat(8'h63, 1'b1, 1'b1);
        t0 = cyc;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n = 0;
        while (bus.block_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abc_latency", 512'(cyc - t0), 512'd54);
        drain();
        pin_abc();

        // Empty message.
        got_q.delete();
        m = {};
        send(m, 1'b1);
        drain();
        pin("empty_w0", 0, 0, 32'h80000000);
        for (int w = 1; w < 16; w++) pin("empty_wrest", 0, w, 32'h00000000);

        // 55 bytes: tail fits exactly, one block.
        got_q.delete();
        m = {};
        for (int i = 0; i < 55; i++) m.push_back(8'(i + 1));
        send(m, 1'b1);
        drain();
        pin("b55_w13", 0, 13, 32'h35363780);
        pin("b55_w15", 0, 15, 32'h000001B8);
        check("b55_count", 512'(got_q.size()), 512'd1);

        // 56 zero bytes: length spills into a second block.
        got_q.delete();
        m = {};
        for (int i = 0; i < 56; i++) m.push_back(8'h00);
        send(m, 1'b1);
        drain();
        pin("b56_blk1_w14", 0, 14, 32'h80000000);
        pin("b56_blk1_w15", 0, 15, 32'h00000000);
        pin("b56_blk2_w0", 1, 0, 32'h00000000);
        pin("b56_blk2_w15", 1, 15, 32'h000001C0);

        // 64 bytes 0x00..0x3F: full data block, then pad block.
        got_q.delete();
        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'(i));
        send(m, 1'b1);
        drain();
        pin("b64_blk1_w0", 0, 0, 32'h00010203);
        pin("b64_blk1_w15", 0, 15, 32'h3C3D3E3F);
        pin("b64_blk2_w0", 1, 0, 32'h80000000);
        pin("b64_blk2_w15", 1, 15, 32'h00000200);

        // Backpressure on "abc".
        got_q.delete();
        bus.block_ready = 1'b0;
        m = {8'h61, 8'h62, 8'h63};
        send(m, 1'b1);
        n = 0;
        while (bus.block_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_held", {511'd0, bus.block_valid}, {511'd0, 1'b1});
            check("bp_in_ready", {511'd0, bus.in_ready}, 512'd0);
        end
        bus.block_ready = 1'b1;
        @(negedge clk);
        check("bp_transfer_first", {511'd0, bus.block_valid}, 512'd0);
        drain();
        pin_abc();

        // Reset in the middle of filling, then "abc" again.
        got_q.delete();
        m = {};
        for (int i = 0; i < 20; i++) m.push_back(8'hAA);
        send(m, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_block_out", bus.block_out, 512'd0);
        check("mid_rst_in_ready", {511'd0, bus.in_ready}, {511'd0, 1'b1});
        check("mid_rst_block_valid", {511'd0, bus.block_valid}, 512'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        m = {8'h61, 8'h62, 8'h63};
        send(m, 1'b1);
        drain();
        pin_abc();
        check("mid_rst_count", 512'(got_q.size()), 512'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Overall time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

endmodule

// File: doc/sha1_padder.md
Name: sha1_padder

Overview:
- Upstream stage of the sha1 core: turns a byte stream into padded, length-terminated 512-bit SHA-1 blocks.
- Each block is presented in exactly the word layout the core's message_in consumes.
- Handles the 0x80 marker, zero fill, the 64-bit bit-length field, and the extra block needed when the tail does not fit.
- A downstream controller pulls blocks through a valid/ready handshake and sequences the core.

Parameters:
- LEN_W, 64, width of the internal bit-length counter; zero-extended into the 64-bit length field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_keep/in_last are valid.
- in_ready  output  1  padder accepts a byte this cycle.
- in_data  input  8  message byte, in message order.
- in_keep  input  1  in_data carries a real byte; 0 is allowed only with in_last=1 (zero-byte terminator).
- in_last  input  1  final beat of the message.
- block_out  output  512  padded block; SHA-1 word i is at [32i+31:32i], first byte of word i at bits [32i+31:32i+24].
- block_valid  output  1  block_out holds a complete block.
- block_last  output  1  current block is the final block of the message.
- block_ready  input  1  consumer takes the block.

Behaviour:
- Reset (async, reset_n=0):
  - state=FILL, pos=0, bitlen=0, buffer=0.
  - in_ready=1, block_valid=0, block_last=0, block_out=0.
- Handshakes:
  - Input beat transfers when in_valid & in_ready.
  - Block transfers when block_valid & block_ready.
- State machine FILL, PAD, ZERO, LEN, EMIT. pos is the 6-bit byte index within the block.
- FILL (in_ready=1):
  - On a beat with in_keep=1: write in_data at pos, pos<=pos+1, bitlen<=bitlen+8.
  - If the beat also has in_last=1: go to PAD.
  - Else if pos was 63: go to EMIT with last=0.
  - Beat with in_keep=0 and in_last=1: go to PAD with no byte written.
  - Beat with in_keep=0 and in_last=0: dropped, no effect.
- PAD (in_ready=0, 1 cycle): write 0x80 at pos, pos<=pos+1.
  - If old pos ≤55: go to ZERO, or LEN directly if old pos=55.
  - If old pos=63: go to EMIT with last=0, then ZERO.
  - Otherwise: go to ZERO.
- ZERO (in_ready=0): write 0x00 at pos, pos<=pos+1, one byte per cycle.
  - When the written byte was pos=55: go to LEN.
  - When the written byte was pos=63: go to EMIT with last=0, returning to ZERO.
- LEN (1 cycle):
  - Write bitlen big-endian into bytes 56..63: block_out[479:448]=bitlen[63:32], block_out[511:480]=bitlen[31:0].
  - Go to EMIT with last=1.
- EMIT:
  - block_valid=1; block_out and block_last are held stable until the transfer.
  - On transfer: clear buffer and pos.
  - Return to FILL if the block came from FILL, to ZERO if it came from PAD/ZERO, to FILL if last=1.
  - On the last=1 transfer, also clear bitlen.
- Hold rule: in_ready=0 in every state except FILL, so input beats offered outside FILL are not taken.
- Arithmetic: bitlen wraps modulo 2^LEN_W; no error is flagged.
- Boundary cases:
  - 55-byte tail gives one block.
  - 56..63-byte tail gives two blocks; the second is all zero plus length.
  - 64-byte aligned message gives full data block(s), then a 0x80+zero+length block.
- Reset mid-operation: immediate return to reset values; a partial block is discarded and never emitted.

Test Plan:
- "abc" (0x61,0x62,0x63 with in_last on 0x63), block_ready=1:
  - One block, block_last=1.
  - block_out[31:0]=0x61626380, words 1..14=0, block_out[511:480]=0x00000018.
  - block_valid first high 54 clocks after the last beat (1 PAD + 52 ZERO + 1 LEN).
- Empty message (single beat in_keep=0, in_last=1):
  - word0=0x80000000, all other words 0 including length.
  - block_last=1.
- 56 bytes of 0x00:
  - Block 1: last=0, word14=0x80000000, word15=0.
  - Block 2: last=1, words 0..14=0, word15=0x000001C0.
- 64 bytes 0x00..0x3F:
  - Block 1: last=0, word0=0x00010203, word15=0x3C3D3E3F; in_ready=0 while it waits.
  - Block 2: last=1, word0=0x80000000, word15=0x00000200.
- Backpressure: hold block_ready=0 for 10 cycles during "abc".
  - block_out/block_last stable, block_valid stays 1, in_ready=0.
  - Transfer occurs on the first cycle with block_ready=1.
- Reset mid-fill: pulse reset_n=0 after 20 bytes, then send "abc".
  - Output is identical to the "abc" case (bitlen=0x18, no stale bytes).
